hr_xfer_fifo: RTL

Transfer FIFO that sits between the ring ports of the hierarchical-ring bridge, one instance per FIFO channel (l0, l1, g0..g3). It is the counterpart of the bridge's FIFO interface: the bridge writes with `enQ`/`FIFO_o` and reads with `deQ`/`FIFO_i`, and this block answers with the head flit and `bfull`. It buffers 144-bit control flits moving from one ring to the other and applies backpressure to the bridge.

---
 rtl/hr_xfer_fifo_if.sv | 28 ++
 rtl/hr_xfer_fifo.sv | 61 ++++++
 2 files changed

// File: rtl/hr_xfer_fifo_if.sv
// Bridge-side FIFO channel bundle: push/pop requests toward the FIFO,
// head flit and status back to the bridge.
interface hr_xfer_fifo_if #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             enQ_i;
  logic [WIDTH-1:0] data_i;
  logic             deQ_i;
  logic [WIDTH-1:0] data_o;
  logic             bfull_o;
  logic             empty_o;
  logic [CW-1:0]    count_o;
  logic             ovf_o;
  logic             udf_o;

  modport master (
    output enQ_i, data_i, deQ_i,
    input  data_o, bfull_o, empty_o, count_o, ovf_o, udf_o
  );

  modport slave (
    input  enQ_i, data_i, deQ_i,
    output data_o, bfull_o, empty_o, count_o, ovf_o, udf_o
  );
endinterface

// File: rtl/hr_xfer_fifo.sv
// Transfer FIFO between hierarchical-ring ports: circular buffer with
// occupancy counter, zero-gated head flit, backpressure and sticky error flags.
module hr_xfer_fifo #(
  parameter int WIDTH      = 144,
  parameter int DEPTH      = 4,
  parameter int FULL_SLACK = 0
) (
  input logic          clk,
  input logic          rst,
  hr_xfer_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] BFULL_LVL = CW'(DEPTH - FULL_SLACK);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             udf;
  logic             push_ok;
  logic             pop_ok;

  // A pop frees the slot a same-cycle push needs, so full + pop still accepts.
  assign pop_ok  = bus.deQ_i && (cnt != '0);
  assign push_ok = bus.enQ_i && ((cnt != FULL_LVL) || pop_ok);

  // Storage is intentionally not reset; output gating hides stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (bus.enQ_i && !push_ok) ovf <= 1'b1;
      if (bus.deQ_i && !pop_ok)  udf <= 1'b1;
    end
  end

  assign bus.data_o  = (cnt != '0) ? mem[rd_ptr] : '0;
  assign bus.bfull_o = (cnt >= BFULL_LVL);
  assign bus.empty_o = (cnt == '0);
  assign bus.count_o = cnt;
  assign bus.ovf_o   = ovf;
  assign bus.udf_o   = udf;
endmodule
